// File: rtl/text_overlay_reader_pkg.sv
// Shared font constants and ROM address helpers for the text overlay.
// Codes 0x00-0x0E are glyphs (0x0E is space); 0x10-0x19 are digits 0-9.
package text_overlay_reader_pkg;

    localparam logic [6:0] FONT_SPACE  = 7'h0E;
    localparam logic [6:0] FONT_DIGIT0 = 7'h10;
    localparam logic [6:0] FONT_LAST   = 7'h19;

    function automatic logic [10:0] rom_pack(
        input logic [6:0] code,
        input logic [2:0] grow
    );
        return {code, 1'b0, grow};
    endfunction

    localparam logic [10:0] BLANK_ADDR = {FONT_SPACE, 4'h0};

    function automatic logic font_code_valid(input logic [6:0] code);
        return (code <= FONT_SPACE) ||
               (code >= FONT_DIGIT0 && code <= FONT_LAST);
    endfunction

endpackage

// File: rtl/text_overlay_reader_buf.sv
// Host-writable character line buffer with combinational read port.
// Reset fills every slot with the space code.
module text_line_buffer
    import text_overlay_reader_pkg::*;
#(
    parameter int N_CHARS = 16,
    parameter int IW      = $clog2(N_CHARS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [6:0]    wr_char,
    input  logic [IW-1:0] rd_idx,
    output logic [6:0]    rd_char
);

    logic [6:0] mem [N_CHARS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CHARS; i++)
                mem[i] <= FONT_SPACE;
        end else if (wr_en && (int'(wr_idx) < N_CHARS)) begin
            mem[wr_idx] <= wr_char;
        end
    end

    // Reads see the pre-write contents during a write cycle.
    assign rd_char = mem[rd_idx];

endmodule

// File: rtl/text_overlay_reader.sv
// Maps scan coordinates to font ROM addresses and serializes glyph rows.
// Two-cycle pipeline; stage 1 lines up with the ROM's registered address.
module text_overlay_reader
    import text_overlay_reader_pkg::*;
#(
    parameter int         X0         = 256,
    parameter int         Y0         = 32,
    parameter int         N_CHARS    = 16,
    parameter int         SCALE_LOG2 = 0,
    parameter logic [7:0] FG_RGB     = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       video_on,
    input  logic [9:0]                 col,
    input  logic [9:0]                 row,
    input  logic [7:0]                 bg_rgb,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_idx,
    input  logic [6:0]                 wr_char,
    output logic [10:0]                rom_addr,
    input  logic [7:0]                 rom_data,
    output logic [7:0]                 rgb_out,
    output logic                       pixel_on,
    output logic                       out_valid
);

    localparam int IW = $clog2(N_CHARS);
    localparam int S  = 1 << SCALE_LOG2;
    localparam int CW = 8 << SCALE_LOG2;

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + N_CHARS * CW);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + 8 * S);

    logic [9:0]    dx;
    logic [9:0]    dy;
    logic          in_win;
    logic [IW-1:0] idx;
    logic [2:0]    glyph_row;
    logic [2:0]    bit_sel;
    logic [6:0]    code;
    logic          blank;

    logic          in_win_d1;
    logic          blank_d1;
    logic [2:0]    bit_sel_d1;
    logic          video_on_d1;
    logic [7:0]    bg_d1;
    logic          lit;

    // Bounds checked on unwrapped values; dx/dy only matter inside.
    assign in_win = video_on &&
                    ({1'b0, col} >= X_LO) && ({1'b0, col} < X_HI) &&
                    ({1'b0, row} >= Y_LO) && ({1'b0, row} < Y_HI);

    assign dx        = col - 10'(X0);
    assign dy        = row - 10'(Y0);
    assign idx       = IW'(dx >> (3 + SCALE_LOG2));
    assign glyph_row = 3'(dy >> SCALE_LOG2);
    assign bit_sel   = 3'(dx >> SCALE_LOG2);
    assign blank     = ~font_code_valid(code);
    assign rom_addr  = in_win ? rom_pack(code, glyph_row) : BLANK_ADDR;

    text_line_buffer #(
        .N_CHARS (N_CHARS),
        .IW      (IW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_char (wr_char),
        .rd_idx  (idx),
        .rd_char (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_win_d1   <= 1'b0;
            blank_d1    <= 1'b0;
            bit_sel_d1  <= 3'd0;
            video_on_d1 <= 1'b0;
            bg_d1       <= 8'h00;
        end else begin
            in_win_d1   <= in_win;
            blank_d1    <= blank;
            bit_sel_d1  <= bit_sel;
            video_on_d1 <= video_on;
            bg_d1       <= bg_rgb;
        end
    end

    assign lit = in_win_d1 & ~blank_d1 & rom_data[3'd7 - bit_sel_d1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_on  <= 1'b0;
            rgb_out   <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            pixel_on  <= lit;
            rgb_out   <= video_on_d1 ? (lit ? FG_RGB : bg_d1) : 8'h00;
            out_valid <= video_on_d1;
        end
    end

endmodule

// File: tb/tb_text_overlay_reader.sv
// Self-checking bench: two overlay instances (scale 1x and 2x) fed by
// behavioural font ROMs, checked against a per-pixel arithmetic model.
module tb_text_overlay_reader;

    localparam int X0 = 256;
    localparam int Y0 = 32;
    localparam int N  = 16;

    typedef struct packed {
        logic [10:0] addr;
        logic        pix;
        logic [7:0]  rgb;
        logic        vld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  col = '0;
    logic [9:0]  row = '0;
    logic [7:0]  bg_rgb = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [6:0]  wr_char = '0;

    logic [10:0] rom_addr0, rom_addr1;
    logic [7:0]  rom_data0, rom_data1;
    logic [7:0]  rgb0, rgb1;
    logic        pix0, pix1, vld0, vld1;

    logic [7:0]  font [2048];
    int          mbuf [N];
    exp_t        prev0, prev1;
    logic [15:0] hist0, hist1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data0 <= font[rom_addr0];
        rom_data1 <= font[rom_addr1];
    end

    text_overlay_reader #(.SCALE_LOG2(0)) dut (
        .clk(clk), .rst(rst), .video_on(video_on), .col(col), .row(row),
        .bg_rgb(bg_rgb), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .rgb_out(rgb0),
        .pixel_on(pix0), .out_valid(vld0)
    );

    text_overlay_reader #(.SCALE_LOG2(1)) dut2 (
        .clk(clk), .rst(rst), .video_on(video_on), .col(col), .row(row),
        .bg_rgb(bg_rgb), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .rgb_out(rgb1),
        .pixel_on(pix1), .out_valid(vld1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int sl, input bit vo, input int c,
                                   input int r, input logic [7:0] bg);
        exp_t e;
        int s, cw, code, gr, bs;
        bit win, ok;
        s  = 1 << sl;
        cw = 8 * s;
        win = vo && c >= X0 && c < X0 + N * cw && r >= Y0 && r < Y0 + 8 * s;
        e.addr = 11'h0E0;
        e.pix  = 1'b0;
        if (win) begin
            code = mbuf[(c - X0) / cw];
            gr   = (r - Y0) / s;
            bs   = ((c - X0) / s) % 8;
            e.addr = 11'(code * 16 + gr);
            ok = code <= 14 || (code >= 16 && code <= 25);
            e.pix = ok && font[code * 16 + gr][7 - bs];
        end
        e.vld = vo;
        e.rgb = !vo ? 8'h00 : (e.pix ? 8'hFF : bg);
        return e;
    endfunction

    task automatic step(input bit vo, input int c, input int r,
                        input logic [7:0] bg, input bit we = 1'b0,
                        input int wi = 0, input int wc = 0);
        exp_t e0, e1;
        video_on = vo;
        col      = 10'(c);
        row      = 10'(r);
        bg_rgb   = bg;
        wr_en    = we;
        wr_idx   = 4'(wi);
        wr_char  = 7'(wc);
        e0 = model(0, vo, c, r, bg);
        e1 = model(1, vo, c, r, bg);
        #1;
        chk("addr_s0", 32'(rom_addr0), 32'(e0.addr));
        chk("addr_s1", 32'(rom_addr1), 32'(e1.addr));
        if (we) mbuf[wi] = wc;
        @(posedge clk);
        #1;
        chk("pix_s0", 32'(pix0), 32'(prev0.pix));
        chk("rgb_s0", 32'(rgb0), 32'(prev0.rgb));
        chk("vld_s0", 32'(vld0), 32'(prev0.vld));
        chk("pix_s1", 32'(pix1), 32'(prev1.pix));
        chk("rgb_s1", 32'(rgb1), 32'(prev1.rgb));
        chk("vld_s1", 32'(vld1), 32'(prev1.vld));
        hist0 = {hist0[14:0], pix0};
        hist1 = {hist1[14:0], pix1};
        prev0 = e0;
        prev1 = e1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pix0", 32'(pix0), 32'd0);
        chk("rst_rgb0", 32'(rgb0), 32'd0);
        chk("rst_vld0", 32'(vld0), 32'd0);
        chk("rst_pix1", 32'(pix1), 32'd0);
        chk("rst_rgb1", 32'(rgb1), 32'd0);
        chk("rst_vld1", 32'(vld1), 32'd0);
        for (int i = 0; i < N; i++) mbuf[i] = 14;
        prev0 = '0;
        prev1 = '0;
        rst = 1'b0;
    endtask

    initial begin
        int rs [6];
        int c, r;
        rs = '{31, 32, 39, 40, 47, 48};
        hist0 = '0;
        hist1 = '0;
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            font[14 * 16 + i]   = 8'h00;
            font[15 * 16 + i]   = 8'hFF;
            font[26 * 16 + i]   = 8'hFF;
        end
        font[16'h005] = 8'h7E;
        font[16'h000] = 8'h18;
        font[16'h110] = 8'h18;
        font[16'h100] = 8'h3C;

        @(posedge clk);
        #1;
        do_reset();

        // Blank-buffer sweep across both windows' edges
        foreach (rs[k])
            for (int cc = 250; cc <= 520; cc++)
                step((cc % 37) != 0, cc, rs[k], 8'($urandom));

        // 'A' in slot 0, glyph row 5
        step(0, 0, 0, 8'h00, 1, 0, 8'h00);
        video_on = 1'b1; col = 10'd256; row = 10'd37;
        #1;
        chk("a_addr_lit", 32'(rom_addr0), 32'h005);
        for (int cc = 256; cc <= 263; cc++) step(1, cc, 37, 8'($urandom));
        step(0, 0, 0, 8'h00);
        chk("a_pattern", 32'(hist0[7:0]), 32'h7E);

        // '1' in slot 3, glyph row 0
        step(0, 0, 0, 8'h00, 1, 3, 8'h11);
        video_on = 1'b1; col = 10'd280; row = 10'd32;
        #1;
        chk("one_addr_lit", 32'(rom_addr0), 32'h110);
        for (int cc = 280; cc <= 287; cc++) step(1, cc, 32, 8'($urandom));
        step(0, 0, 0, 8'h00);
        chk("one_pattern", 32'(hist0[7:0]), 32'h18);

        // Undefined codes render blank even with lit ROM rows
        step(0, 0, 0, 8'h00, 1, 1, 8'h1A);
        step(0, 0, 0, 8'h00, 1, 2, 8'h0F);
        video_on = 1'b1; col = 10'd264; row = 10'd32;
        #1;
        chk("bad_addr_lit", 32'(rom_addr0), 32'h1A0);
        for (int rr = 32; rr <= 39; rr++)
            for (int cc = 264; cc <= 279; cc++)
                step(1, cc, rr, 8'($urandom));

        // 2x scale: rows 32/33 share glyph row 0, cols 262..265 lit
        for (int rr = 32; rr <= 33; rr++)
            for (int cc = 262; cc <= 265; cc++)
                step(1, cc, rr, 8'($urandom));
        step(0, 0, 0, 8'h00);
        chk("scale_pattern", 32'(hist1[7:0]), 32'hFF);

        // Write and read of the same slot in one cycle
        step(1, 256, 32, 8'h55, 1, 0, 8'h10);
        video_on = 1'b1; col = 10'd257; row = 10'd32;
        #1;
        chk("wr_new_addr", 32'(rom_addr0), 32'h100);
        step(1, 257, 32, 8'hAA);

        // Randomised traffic with host writes interleaved
        for (int n = 0; n < 1500; n++) begin
            c = ($urandom_range(1) == 1) ? int'($urandom_range(540, 240))
                                         : int'($urandom_range(799, 0));
            r = ($urandom_range(1) == 1) ? int'($urandom_range(52, 28))
                                         : int'($urandom_range(524, 0));
            if ($urandom_range(9) == 0)
                step($urandom_range(4) != 0, c, r, 8'($urandom), 1,
                     int'($urandom_range(15)),
                     ($urandom_range(3) == 0) ? int'($urandom_range(127))
                                              : int'($urandom_range(31)));
            else
                step($urandom_range(4) != 0, c, r, 8'($urandom));
        end

        // Reset in the middle of a lit line
        step(1, 256, 37, 8'h00, 1, 0, 8'h00);
        for (int cc = 256; cc <= 260; cc++) step(1, cc, 37, 8'($urandom));
        do_reset();
        video_on = 1'b1; col = 10'd256; row = 10'd37;
        #1;
        chk("rb_addr_s0", 32'(rom_addr0), 32'h0E5);
        chk("rb_addr_s1", 32'(rom_addr1), 32'h0E2);
        for (int cc = 256; cc <= 270; cc++) step(1, cc, 37, 8'($urandom));
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_overlay_reader.md
Name: text_overlay_reader

Overview:
- Read side of the 8x8 font ROM: turns VGA scan coordinates into font ROM addresses and serializes the returned glyph rows into an on-screen text overlay.
- Holds a small host-writable character line buffer, placed at a fixed screen position.
- Sits between the VGA timing generator, the font ROM and the final pixel mux.
- Compensates for the ROM's one-cycle registered-address latency and delays background pixels to match.

Parameters:
- X0, 256, left pixel column of the text line
- Y0, 32, top pixel row of the text line
- N_CHARS, 16, characters in the line buffer (power of two, 2..32)
- SCALE_LOG2, 0, glyph magnification exponent: each font pixel is 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels (0..2)
- FG_RGB, 8'hFF, overlay colour for lit glyph pixels

Ports:
- clk  in  1  system clock, one pixel per cycle
- rst  in  1  asynchronous, active-high reset
- video_on  in  1  active-display qualifier for col/row
- col  in  10  current pixel column
- row  in  10  current pixel row
- bg_rgb  in  8  underlying pixel, same cycle as col/row
- wr_en  in  1  write strobe for the line buffer
- wr_idx  in  $clog2(N_CHARS)  character slot to write
- wr_char  in  7  character code to write
- rom_addr  out  11  font ROM address; the ROM registers it internally
- rom_data  in  8  font ROM row data, valid one cycle after rom_addr; bit 7 = leftmost pixel
- rgb_out  out  8  overlaid pixel
- pixel_on  out  1  glyph pixel lit at this output pixel
- out_valid  out  1  delayed video_on

Behaviour:
- Geometry:
  - CW = 8 << SCALE_LOG2.
  - Window: X0 ≤ col < X0 + N_CHARS·CW and Y0 ≤ row < Y0 + 8·(1<<SCALE_LOG2) and video_on.
  - Compare against bounds directly; never rely on wrapped subtraction.
- Stage 0 (combinational on inputs):
  - dx = col − X0, dy = row − Y0
  - idx = dx >> (3+SCALE_LOG2)
  - glyph_row = (dy >> SCALE_LOG2)[2:0]
  - bit_sel = (dx >> SCALE_LOG2)[2:0]
  - code = buf[idx]
  - rom_addr = {code, 1'b0, glyph_row}, i.e. code·16 + row.
  - Outside the window, rom_addr = {7'h0E, 4'h0} (blank glyph) so ROM output never floats.
- Defined codes: 0x00–0x0E and 0x10–0x19 (0x0E = space, 0x10–0x19 = digits 0–9). Any other code is treated as blank: pixel forced 0 regardless of rom_data.
- Stage 1 (registered): in_win_d1, blank_d1, bit_sel_d1, video_on_d1, bg_d1.
- Stage 2 (registered):
  - pixel_on = in_win_d1 & ~blank_d1 & rom_data[7−bit_sel_d1]
  - rgb_out = pixel_on ? FG_RGB : bg_d1, forced to 0 when ~video_on_d1
  - out_valid = video_on_d1
- Latency: exactly 2 cycles from col/row/bg_rgb to rgb_out/pixel_on/out_valid, every cycle, with no stalls.
- Line buffer:
  - N_CHARS × 7-bit registers.
  - On wr_en, buf[wr_idx] ← wr_char at the clock edge. Out-of-range wr_idx is ignored.
  - A write and a read of the same slot in one cycle: the read returns the old code; the new code is seen from the next cycle.
- Reset (async, any time):
  - All pipeline regs, rgb_out, pixel_on and out_valid go to 0.
  - All buf entries go to 0x0E (space).
  - Pixels in flight are discarded. The first valid output occurs 2 cycles after the first post-reset input with video_on=1.
- Row/column wrap at frame end needs no special handling; window tests are stateless per pixel.

Decomposition:
- Shared package:
  - FONT_SPACE = 7'h0E
  - FONT_DIGIT0 = 7'h10
  - FONT_LAST = 7'h19
  - font_code_valid() function
  - ROM address packing function {code, 1'b0, row}
- One natural sub-module, text_line_buffer: register array, write port, async reset-to-space, combinational read.

Test Plan:
- Reset, no writes; sweep full frame → pixel_on never 1; rgb_out equals bg_rgb delayed 2 cycles inside video_on and is 0 outside.
- Write code 0x00 ('A') to slot 0; drive row=37, col=256..263 → rom_addr=0x005; pixel_on pattern 0,1,1,1,1,1,1,0 appears on cycles +2..+9; rgb_out=FF on the lit pixels.
- Write 0x11 ('1') to slot 3; row=32, col=280..287 → rom_addr=0x110; pixel_on lit only at col 283,284.
- Write 0x1A and 0x0F to slots 1 and 2; scan those cells → pixel_on stays 0 everywhere; rom_addr for these cells is 0x1A0/0x0F0 (no out-of-range assertion required).
- SCALE_LOG2=1, code 0x00 in slot 0; rows 32,33 both → glyph_row 0; cols 262..265 (font bits 3–4) → pixel_on=1 for 4 pixels.
- wr_en to slot 0 (0x00 → 0x10) on the same cycle col=256,row=32 → that pixel uses 'A' row 0; next cycle at col=257 uses '0' (rom_addr=0x100). Also assert rst mid-line → outputs 0 within the same cycle; buffer reads back 0x0E.
